// File: rtl/io_timer.sv
// Memory-mapped dual-channel countdown timer with a shared prescaler.
// Eight word registers at BASE_ADDR; level interrupt per channel.
module io_timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          WIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             we,
  input  logic             re,
  output logic [WIDTH-1:0] data_out,
  output logic             data_oe,
  output logic [1:0]       irq
);

  // Bus semantics: a write commits at the rising edge when we=1 and the
  // address is in the window; reads are combinational and side-effect free.
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [5:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] load_q  [2];
  logic [WIDTH-1:0] load_d  [2];
  logic [WIDTH-1:0] count_q [2];
  logic [WIDTH-1:0] count_d [2];
  logic [1:0]       expired_q, expired_d;

  logic       sel;
  logic [2:0] off;
  logic       wr_en;
  logic       tick;
  logic [1:0] en, ar, ie;
  logic [1:0] fired;
  logic [1:0] en_clr;
  logic [1:0] clr;

  assign sel   = (addr[15:3] == BASE_ADDR[15:3]);
  assign off   = addr[2:0];
  assign wr_en = we & sel;
  assign tick  = (pcnt_q == '0);

  assign en = {ctrl_q[3], ctrl_q[0]};
  assign ar = {ctrl_q[4], ctrl_q[1]};
  assign ie = {ctrl_q[5], ctrl_q[2]};

  assign irq     = expired_q & ie;
  assign data_oe = re & sel;

  always_comb begin
    presc_d = presc_q;
    load_d  = load_q;
    count_d = count_q;
    pcnt_d  = tick ? presc_q : (pcnt_q - ONE);
    fired   = '0;
    en_clr  = '0;
    clr     = '0;

    for (int i = 0; i < 2; i++) begin
      if (tick && en[i]) begin
        if (count_q[i] == '0) begin
          fired[i] = 1'b1;
          if (ar[i]) count_d[i] = load_q[i];
          else       en_clr[i]  = 1'b1;
        end else begin
          count_d[i] = count_q[i] - ONE;
        end
      end
    end

    ctrl_d = ctrl_q & ~{2'b00, en_clr[1], 2'b00, en_clr[0]};

    // Bus writes are applied last so they take precedence over timer updates.
    if (wr_en) begin
      case (off)
        3'd0: ctrl_d = data_in[5:0];
        3'd1: begin
          presc_d = data_in;
          pcnt_d  = data_in;
        end
        3'd2: load_d[0]  = data_in;
        3'd3: count_d[0] = data_in;
        3'd4: load_d[1]  = data_in;
        3'd5: count_d[1] = data_in;
        3'd6: clr        = data_in[1:0];
        default: ;
      endcase
    end

    // A new expiry beats a same-cycle write-1-to-clear.
    expired_d = (expired_q & ~clr) | fired;
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (off)
        3'd0: data_out[5:0] = ctrl_q;
        3'd1: data_out      = presc_q;
        3'd2: data_out      = load_q[0];
        3'd3: data_out      = count_q[0];
        3'd4: data_out      = load_q[1];
        3'd5: data_out      = count_q[1];
        3'd6: data_out[1:0] = expired_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      load_q    <= '{default: '0};
      count_q   <= '{default: '0};
      expired_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: a cycle-level behavioural model checked every
// negedge, plus hand-computed register reads along each scenario.
module tb_io_timer;

  localparam int W = 16;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [15:0]  addr    = '0;
  logic [W-1:0] data_in = '0;
  logic         we      = 1'b0;
  logic         re      = 1'b0;
  logic [W-1:0] data_out;
  logic         data_oe;
  logic [1:0]   irq;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;
  logic [W-1:0] exp_q[$];

  io_timer #(.BASE_ADDR(16'hFF00), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .re       (re),
    .data_out (data_out),
    .data_oe  (data_oe),
    .irq      (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  int m_presc, m_pcnt;
  int m_load[2], m_count[2];
  bit m_en[2], m_ar[2], m_ie[2], m_exp[2];

  function automatic void model_reset();
    m_presc = 0;
    m_pcnt  = 0;
    for (int c = 0; c < 2; c++) begin
      m_load[c] = 0; m_count[c] = 0;
      m_en[c] = 0; m_ar[c] = 0; m_ie[c] = 0; m_exp[c] = 0;
    end
  endfunction

  function automatic bit in_window(logic [15:0] a);
    return (a & 16'hFFF8) == 16'hFF00;
  endfunction

  function automatic int m_read(int o);
    case (o)
      0: return int'(m_en[0]) + 2 * int'(m_ar[0]) + 4 * int'(m_ie[0]) +
                8 * int'(m_en[1]) + 16 * int'(m_ar[1]) + 32 * int'(m_ie[1]);
      1: return m_presc;
      2: return m_load[0];
      3: return m_count[0];
      4: return m_load[1];
      5: return m_count[1];
      6: return int'(m_exp[0]) + 2 * int'(m_exp[1]);
      default: return 0;
    endcase
  endfunction

  function automatic void model_step();
    int o, d, next_pcnt;
    bit tk;
    bit fired[2];
    o  = (we && in_window(addr)) ? int'(addr[2:0]) : -1;
    d  = int'(data_in);
    tk = (m_pcnt == 0);
    next_pcnt = tk ? m_presc : m_pcnt - 1;
    for (int c = 0; c < 2; c++) begin
      fired[c] = 0;
      if (tk && m_en[c]) begin
        if (m_count[c] > 0) m_count[c] = m_count[c] - 1;
        else begin
          fired[c] = 1;
          if (m_ar[c]) m_count[c] = m_load[c];
          else         m_en[c]    = 0;
        end
      end
      if (fired[c]) m_exp[c] = 1;
    end
    case (o)
      0: begin
        m_en[0] = d[0]; m_ar[0] = d[1]; m_ie[0] = d[2];
        m_en[1] = d[3]; m_ar[1] = d[4]; m_ie[1] = d[5];
      end
      1: begin m_presc = d; next_pcnt = d; end
      2: m_load[0]  = d;
      3: m_count[0] = d;
      4: m_load[1]  = d;
      5: m_count[1] = d;
      6: for (int c = 0; c < 2; c++) if (d[c] && !fired[c]) m_exp[c] = 0;
      default: ;
    endcase
    m_pcnt = next_pcnt;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : compare
    int e;
    forever begin
      @(negedge clk);
      if (!done) begin
        e = in_window(addr) ? m_read(int'(addr[2:0])) : 0;
        check("cmp_data_out", data_out, e);
        check("cmp_data_oe", data_oe, re && in_window(addr));
        check("cmp_irq", irq, {m_exp[1] & m_ie[1], m_exp[0] & m_ie[0]});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int o, input logic [15:0] d);
    addr    = 16'hFF00 | 16'(o);
    data_in = d;
    we      = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic expect_rd(input string name, input int o, input logic [15:0] v);
    exp_q.push_back(v);
    addr = 16'hFF00 | 16'(o);
    re   = 1'b1;
    #1;
    check(name, data_out, exp_q.pop_front());
    check({name, "_oe"}, data_oe, 1);
    re = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values and window decode
    for (int i = 0; i < 8; i++) begin
      expect_rd("rst_reg", i, 16'h0000);
      idle(1);
    end
    check("rst_irq", irq, 2'b00);
    addr = 16'hFEFF; re = 1'b1; #1;
    check("outside_oe", data_oe, 0);
    check("outside_data", data_out, 0);
    re = 1'b0; addr = 16'hFF00; #1;
    check("no_re_oe", data_oe, 0);
    idle(1);

    // Periodic channel 0, PRESC=0, LOAD0=3
    bus_wr(1, 16'h0000);
    bus_wr(2, 16'h0003);
    bus_wr(3, 16'h0003);
    bus_wr(0, 16'h0007);
    expect_rd("c0_start", 3, 16'h0003);
    idle(3);
    expect_rd("c0_at_zero", 3, 16'h0000);
    expect_rd("st_before_exp", 6, 16'h0000);
    check("irq_before_exp", irq, 2'b00);
    idle(1);
    expect_rd("st_first_exp", 6, 16'h0001);
    expect_rd("c0_reloaded", 3, 16'h0003);
    check("irq_first_exp", irq, 2'b01);
    bus_wr(6, 16'h0001);
    expect_rd("st_cleared", 6, 16'h0000);
    check("irq_cleared", irq, 2'b00);
    idle(2);
    expect_rd("st_pre_second", 6, 16'h0000);
    idle(1);
    expect_rd("st_second_exp", 6, 16'h0001);
    check("irq_second_exp", irq, 2'b01);

    // Clear lands on the same edge as the next expiry: set wins
    idle(3);
    bus_wr(6, 16'h0001);
    expect_rd("st_clear_vs_set", 6, 16'h0001);
    check("irq_clear_vs_set", irq, 2'b01);
    expect_rd("c0_after_race", 3, 16'h0003);
    bus_wr(0, 16'h0000);
    bus_wr(6, 16'h0003);
    check("irq_after_disable", irq, 2'b00);

    // COUNT0 write on a tick edge wins over the decrement
    expect_rd("c0_frozen", 3, 16'h0002);
    bus_wr(0, 16'h0001);
    bus_wr(3, 16'h0010);
    expect_rd("c0_write_wins", 3, 16'h0010);
    idle(1);
    expect_rd("c0_decrement", 3, 16'h000F);
    bus_wr(0, 16'h0000);
    expect_rd("c0_stopped", 3, 16'h000E);

    // One-shot channel 1 with PRESC=4: expiry 15 clocks after PRESC write
    bus_wr(1, 16'h0004);
    bus_wr(5, 16'h0002);
    bus_wr(0, 16'h0028);
    idle(12);
    expect_rd("st1_pre", 6, 16'h0000);
    expect_rd("c1_pre", 5, 16'h0000);
    idle(1);
    expect_rd("st1_exp", 6, 16'h0002);
    check("irq1_exp", irq, 2'b10);
    expect_rd("ctrl_en1_off", 0, 16'h0020);
    expect_rd("c1_zero", 5, 16'h0000);
    idle(10);
    expect_rd("c1_stays_zero", 5, 16'h0000);
    expect_rd("ctrl_still_off", 0, 16'h0020);

    // Asynchronous reset mid-count
    bus_wr(1, 16'h0000);
    bus_wr(3, 16'h0005);
    bus_wr(0, 16'h0003);
    expect_rd("c0_five", 3, 16'h0005);
    idle(1);
    expect_rd("c0_four", 3, 16'h0004);
    #2 rst_n = 1'b0;
    #1;
    expect_rd("arst_c0", 3, 16'h0000);
    expect_rd("arst_ctrl", 0, 16'h0000);
    expect_rd("arst_status", 6, 16'h0000);
    expect_rd("arst_presc", 1, 16'h0000);
    check("arst_irq", irq, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    expect_rd("post_rst_c0", 3, 16'h0000);
    expect_rd("post_rst_ctrl", 0, 16'h0000);
    expect_rd("post_rst_status", 6, 16'h0000);
    check("post_rst_irq", irq, 2'b00);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
